urx_cmd: RTL and testbench

URX_CMD -- requirements
Module: urx_cmd

---
 rtl/urx_pkg.sv | 26 ++
 rtl/urx_byte.sv | 137 +++++++++++++
 rtl/urx_cmd.sv | 97 +++++++++
 tb/tb_urx_cmd.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/urx_pkg.sv
// Shared types and constants for the UART register-command receiver.
// Bit-FSM states, frame byte indices and the command module ID.
package urx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_HI
   } urx_state_e;

   localparam int unsigned URX_FRAME_LEN = 4;
   localparam logic [6:0]  URX_MOD_ID    = 7'h02;

   localparam logic [1:0] IDX_CMD    = 2'd0;
   localparam logic [1:0] IDX_ADDR_H = 2'd1;
   localparam logic [1:0] IDX_ADDR_L = 2'd2;
   localparam logic [1:0] IDX_DATA   = 2'(URX_FRAME_LEN - 1);

   function automatic logic cmd_ok(input logic [7:0] cmd);
      return cmd[6:0] == URX_MOD_ID;
   endfunction

endpackage

// File: rtl/urx_byte.sv
// UART byte receiver: 2-FF synchronizer, baud counter and bit FSM (8N1).
// Define URX_PARITY_EN to expect an even-parity bit between bit7 and stop.
module urx_byte
   import urx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       byte_vld,
   output logic [7:0] byte_data,
   output logic       byte_err,
   output logic       rx_busy
);

   localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
   localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

   logic [1:0]  sync_q;
   logic        rx_s;
   urx_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        vld_d, err_d;
   logic        stop_ok;
`ifdef URX_PARITY_EN
   logic        par_q, par_d;
`endif

   assign rx_s      = sync_q[1];
   assign byte_data = shift_q;
   assign rx_busy   = (state_q != ST_IDLE);

`ifdef URX_PARITY_EN
   assign stop_ok = rx_s && (par_q == ^shift_q);
`else
   assign stop_ok = rx_s;
`endif

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q   <= '1;
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         byte_vld <= 1'b0;
         byte_err <= 1'b0;
`ifdef URX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         sync_q   <= {sync_q[0], uart_rx};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         byte_vld <= vld_d;
         byte_err <= err_d;
`ifdef URX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
`ifdef URX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         // Half-bit recheck rejects glitches and centres every later sample.
         ST_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef URX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef URX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               par_d   = rx_s;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == DIV_M1) begin
               cnt_d = '0;
               if (stop_ok) begin
                  vld_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_WAIT_HI;
               end
            end
         end
         ST_WAIT_HI: begin
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/urx_cmd.sv
// UART register-command decoder: assembles CMD/ADDR_H/ADDR_L/DATA frames into
// cfg_wr/cfg_rd strobes, with an inter-byte gap timeout. Option: URX_PARITY_EN.
module urx_cmd
   import urx_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 868,
   parameter int unsigned GAP_BITS = 16
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        uart_rx,
   output logic        cfg_wr,
   output logic        cfg_rd,
   output logic [15:0] cfg_addr,
   output logic [7:0]  cfg_wdata,
   output logic        err_frm,
   output logic        err_cmd
);

   localparam logic [31:0] GAP_LIMIT = 32'(GAP_BITS * BAUD_DIV);

   logic        byte_vld, byte_err, rx_busy;
   logic [7:0]  byte_data;
   logic [1:0]  idx_q;
   logic        is_wr_q;
   logic [7:0]  addr_h_q, addr_l_q;
   logic [31:0] gap_q;

   urx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_byte (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .uart_rx   (uart_rx),
      .byte_vld  (byte_vld),
      .byte_data (byte_data),
      .byte_err  (byte_err),
      .rx_busy   (rx_busy)
   );

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cfg_wr    <= 1'b0;
         cfg_rd    <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         err_frm   <= 1'b0;
         err_cmd   <= 1'b0;
         idx_q     <= IDX_CMD;
         is_wr_q   <= 1'b0;
         addr_h_q  <= '0;
         addr_l_q  <= '0;
         gap_q     <= '0;
      end else begin
         cfg_wr  <= 1'b0;
         cfg_rd  <= 1'b0;
         err_frm <= 1'b0;
         err_cmd <= 1'b0;
         if (byte_err) begin
            err_frm <= 1'b1;
            idx_q   <= IDX_CMD;
         end else if (byte_vld) begin
            gap_q <= '0;
            case (idx_q)
               IDX_CMD: begin
                  if (cmd_ok(byte_data)) begin
                     is_wr_q <= byte_data[7];
                     idx_q   <= IDX_ADDR_H;
                  end else begin
                     err_cmd <= 1'b1;
                  end
               end
               IDX_ADDR_H: begin
                  addr_h_q <= byte_data;
                  idx_q    <= IDX_ADDR_L;
               end
               IDX_ADDR_L: begin
                  addr_l_q <= byte_data;
                  idx_q    <= IDX_DATA;
               end
               default: begin
                  cfg_wr   <= is_wr_q;
                  cfg_rd   <= !is_wr_q;
                  cfg_addr <= {addr_h_q, addr_l_q};
                  if (is_wr_q) cfg_wdata <= byte_data;
                  idx_q    <= IDX_CMD;
               end
            endcase
         // Gap timer runs only while the line is idle between bytes of a frame.
         end else if (idx_q != IDX_CMD && !rx_busy) begin
            if (gap_q >= GAP_LIMIT) idx_q <= IDX_CMD;
            else                    gap_q <= gap_q + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_urx_cmd.sv
// Self-checking bench for urx_cmd: directed scenarios plus random back-to-back frames.
// A fast instance (BAUD_DIV=16) carries most tests; a BAUD_DIV=868 instance runs one frame.
module tb_urx_cmd;

   localparam int unsigned FAST_DIV = 16;
   localparam int unsigned SLOW_DIV = 868;
   localparam int unsigned GAP      = 16;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_fast = 1'b1;
   logic rx_slow = 1'b1;

   logic        wr_f, rd_f, efrm_f, ecmd_f;
   logic [15:0] addr_f;
   logic [7:0]  wdata_f;
   logic        wr_s, rd_s, efrm_s, ecmd_s;
   logic [15:0] addr_s;
   logic [7:0]  wdata_s;

   ev_t obs_q[$];
   ev_t slow_q[$];
   int  frm_cnt = 0, cmd_cnt = 0, excl_viol = 0;
   int  n_cmp = 0, n_err = 0;
   logic [7:0] last_wdata = 8'h00;

   always #5 clk = ~clk;

   urx_cmd #(.BAUD_DIV(FAST_DIV), .GAP_BITS(GAP)) dut (
      .clk_sys(clk), .rst_n(rst_n), .uart_rx(rx_fast),
      .cfg_wr(wr_f), .cfg_rd(rd_f), .cfg_addr(addr_f), .cfg_wdata(wdata_f),
      .err_frm(efrm_f), .err_cmd(ecmd_f));

   urx_cmd #(.BAUD_DIV(SLOW_DIV), .GAP_BITS(GAP)) dut_slow (
      .clk_sys(clk), .rst_n(rst_n), .uart_rx(rx_slow),
      .cfg_wr(wr_s), .cfg_rd(rd_s), .cfg_addr(addr_s), .cfg_wdata(wdata_s),
      .err_frm(efrm_s), .err_cmd(ecmd_s));

   always @(negedge clk) begin
      ev_t e;
      if (wr_f || rd_f) begin
         e.wr = wr_f; e.addr = addr_f; e.wdata = wdata_f;
         obs_q.push_back(e);
      end
      if (wr_f && rd_f) excl_viol++;
      if (efrm_f) frm_cnt++;
      if (ecmd_f) cmd_cnt++;
      if (wr_s || rd_s) begin
         e.wr = wr_s; e.addr = addr_s; e.wdata = wdata_s;
         slow_q.push_back(e);
      end
   end

   task automatic drive_line(input logic v, input int unsigned n, input bit slow);
      if (slow) rx_slow = v; else rx_fast = v;
      repeat (n) @(negedge clk);
   endtask

   // nbits < 8 aborts the byte after that many data bits and returns the line high.
   task automatic send_byte(input logic [7:0] b, input logic stop_v, input int unsigned nbits, input bit slow);
      int unsigned div;
      div = slow ? SLOW_DIV : FAST_DIV;
      drive_line(1'b0, div, slow);
      for (int i = 0; i < int'(nbits); i++) drive_line(b[i], div, slow);
      if (nbits < 8) begin
         drive_line(1'b1, div, slow);
         return;
      end
`ifdef URX_PARITY_EN
      drive_line(^b, div, slow);
`endif
      drive_line(stop_v, div, slow);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al,
                             input logic [7:0] d, input bit slow);
      send_byte(c, 1'b1, 8, slow);
      send_byte(ah, 1'b1, 8, slow);
      send_byte(al, 1'b1, 8, slow);
      send_byte(d, 1'b1, 8, slow);
   endtask

   task automatic clear_obs();
      obs_q.delete();
      frm_cnt = 0;
      cmd_cnt = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({wr_f, rd_f, addr_f, wdata_f, efrm_f, ecmd_f} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_fast: got %h want 0", {wr_f, rd_f, addr_f, wdata_f, efrm_f, ecmd_f});
      end
      n_cmp++;
      if ({wr_s, rd_s, addr_s, wdata_s, efrm_s, ecmd_s} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_slow: got %h want 0", {wr_s, rd_s, addr_s, wdata_s, efrm_s, ecmd_s});
      end
      rst_n = 1'b1;
      last_wdata = 8'h00;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_write_slow();
      slow_q.delete();
      send_frame(8'h82, 8'h00, 8'h02, 8'h42, 1'b1);
      drive_line(1'b1, 2 * SLOW_DIV, 1'b1);
      n_cmp++;
      if (slow_q.size() !== 1) begin
         n_err++;
         $display("FAIL slow_wr_count: got %0d want 1", slow_q.size());
      end else begin
         n_cmp++;
         if ({slow_q[0].wr, slow_q[0].addr, slow_q[0].wdata} !== {1'b1, 16'h0002, 8'h42}) begin
            n_err++;
            $display("FAIL slow_wr_fields: got wr=%b addr=%h data=%h want wr=1 addr=0002 data=42",
                     slow_q[0].wr, slow_q[0].addr, slow_q[0].wdata);
         end
      end
   endtask

   task automatic test_write();
      clear_obs();
      send_frame(8'h82, 8'h00, 8'h02, 8'h42, 1'b0);
      last_wdata = 8'h42;
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL write_count: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b1, 16'h0002, 8'h42}) begin
            n_err++;
            $display("FAIL write_fields: got wr=%b addr=%h data=%h want wr=1 addr=0002 data=42",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
         end
      end
   endtask

   task automatic test_read();
      clear_obs();
      send_frame(8'h02, 8'h00, 8'h85, 8'h00, 1'b0);
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL read_count: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b0, 16'h0085, last_wdata}) begin
            n_err++;
            $display("FAIL read_fields: got wr=%b addr=%h data=%h want wr=0 addr=0085 data=%h",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata, last_wdata);
         end
      end
   endtask

   task automatic test_frame_err();
      clear_obs();
      send_byte(8'h82, 1'b1, 8, 1'b0);
      send_byte(8'h00, 1'b1, 8, 1'b0);
      send_byte(8'h00, 1'b0, 8, 1'b0);
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      send_frame(8'h82, 8'h00, 8'h03, 8'h20, 1'b0);
      last_wdata = 8'h20;
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (frm_cnt !== 1) begin
         n_err++;
         $display("FAIL frm_err_count: got %0d want 1", frm_cnt);
      end
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL frm_strobe_count: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b1, 16'h0003, 8'h20}) begin
            n_err++;
            $display("FAIL frm_fields: got wr=%b addr=%h data=%h want wr=1 addr=0003 data=20",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
         end
      end
   endtask

   task automatic test_gap();
      clear_obs();
      send_byte(8'h82, 1'b1, 8, 1'b0);
      send_byte(8'h00, 1'b1, 8, 1'b0);
      send_byte(8'h04, 1'b1, 8, 1'b0);
      drive_line(1'b1, 20 * FAST_DIV, 1'b0);
      send_frame(8'h82, 8'h00, 8'h04, 8'h55, 1'b0);
      last_wdata = 8'h55;
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (frm_cnt + cmd_cnt !== 0) begin
         n_err++;
         $display("FAIL gap_errors: got frm=%0d cmd=%0d want 0 0", frm_cnt, cmd_cnt);
      end
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL gap_strobe_count: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b1, 16'h0004, 8'h55}) begin
            n_err++;
            $display("FAIL gap_fields: got wr=%b addr=%h data=%h want wr=1 addr=0004 data=55",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
         end
      end
   endtask

   task automatic test_bad_cmd();
      clear_obs();
      send_byte(8'h81, 1'b1, 8, 1'b0);
      send_frame(8'h82, 8'h00, 8'h06, 8'h03, 1'b0);
      last_wdata = 8'h03;
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (cmd_cnt !== 1) begin
         n_err++;
         $display("FAIL bad_cmd_count: got %0d want 1", cmd_cnt);
      end
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL bad_cmd_strobes: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b1, 16'h0006, 8'h03}) begin
            n_err++;
            $display("FAIL bad_cmd_fields: got wr=%b addr=%h data=%h want wr=1 addr=0006 data=03",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
         end
      end
   endtask

   task automatic test_glitch();
      clear_obs();
      send_byte(8'h82, 1'b1, 8, 1'b0);
      send_byte(8'h00, 1'b1, 8, 1'b0);
      drive_line(1'b1, FAST_DIV, 1'b0);
      drive_line(1'b0, FAST_DIV / 4, 1'b0);
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      send_byte(8'h07, 1'b1, 8, 1'b0);
      send_byte(8'h11, 1'b1, 8, 1'b0);
      last_wdata = 8'h11;
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (frm_cnt + cmd_cnt !== 0) begin
         n_err++;
         $display("FAIL glitch_errors: got frm=%0d cmd=%0d want 0 0", frm_cnt, cmd_cnt);
      end
      n_cmp++;
      if (obs_q.size() !== 1) begin
         n_err++;
         $display("FAIL glitch_strobes: got %0d want 1", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata} !== {1'b1, 16'h0007, 8'h11}) begin
            n_err++;
            $display("FAIL glitch_fields: got wr=%b addr=%h data=%h want wr=1 addr=0007 data=11",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_obs();
      send_byte(8'h82, 1'b1, 8, 1'b0);
      send_byte(8'h00, 1'b1, 8, 1'b0);
      send_byte(8'h02, 1'b1, 8, 1'b0);
      drive_line(1'b0, FAST_DIV, 1'b0);
      drive_line(1'b0, FAST_DIV, 1'b0);
      drive_line(1'b1, FAST_DIV / 2, 1'b0);
      rst_n = 1'b0;
      rx_fast = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({wr_f, rd_f, addr_f, wdata_f, efrm_f, ecmd_f} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %h want 0", {wr_f, rd_f, addr_f, wdata_f, efrm_f, ecmd_f});
      end
      rst_n = 1'b1;
      last_wdata = 8'h00;
      drive_line(1'b1, 20 * FAST_DIV, 1'b0);
      n_cmp++;
      if (obs_q.size() !== 0) begin
         n_err++;
         $display("FAIL reset_mid_no_strobe: got %0d want 0", obs_q.size());
      end
      send_frame(8'h02, 8'h12, 8'h34, 8'h99, 1'b0);
      send_frame(8'h82, 8'h00, 8'h09, 8'h5A, 1'b0);
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (obs_q.size() !== 2) begin
         n_err++;
         $display("FAIL reset_mid_next: got %0d strobes want 2", obs_q.size());
      end else begin
         n_cmp++;
         if ({obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata, obs_q[1].wr, obs_q[1].addr, obs_q[1].wdata}
             !== {1'b0, 16'h1234, 8'h00, 1'b1, 16'h0009, 8'h5A}) begin
            n_err++;
            $display("FAIL reset_mid_fields: got %b/%h/%h %b/%h/%h want 0/1234/00 1/0009/5a",
                     obs_q[0].wr, obs_q[0].addr, obs_q[0].wdata, obs_q[1].wr, obs_q[1].addr, obs_q[1].wdata);
         end
      end
      last_wdata = 8'h5A;
   endtask

   task automatic test_back_to_back();
      ev_t exp_q[$];
      ev_t e;
      int  exp_cmd;
      logic [7:0] c, ah, al, d;
      clear_obs();
      exp_cmd = 0;
      for (int f = 0; f < 20; f++) begin
         if ($urandom_range(0, 4) == 0) begin
            c = 8'($urandom);
            if (c[6:0] == 7'h02) c[0] = 1'b1;
            exp_cmd++;
            send_byte(c, 1'b1, 8, 1'b0);
         end else begin
            c  = {1'($urandom), 7'h02};
            ah = 8'($urandom);
            al = 8'($urandom);
            d  = 8'($urandom);
            if (c[7]) last_wdata = d;
            e.wr = c[7]; e.addr = {ah, al}; e.wdata = last_wdata;
            exp_q.push_back(e);
            send_frame(c, ah, al, d, 1'b0);
         end
      end
      drive_line(1'b1, 2 * FAST_DIV, 1'b0);
      n_cmp++;
      if (cmd_cnt !== exp_cmd || frm_cnt !== 0) begin
         n_err++;
         $display("FAIL b2b_errors: got cmd=%0d frm=%0d want cmd=%0d frm=0", cmd_cnt, frm_cnt, exp_cmd);
      end
      n_cmp++;
      if (obs_q.size() !== exp_q.size()) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if ({obs_q[i].wr, obs_q[i].addr, obs_q[i].wdata} !== {exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata}) begin
               n_err++;
               $display("FAIL b2b_frame%0d: got %b/%h/%h want %b/%h/%h", i,
                        obs_q[i].wr, obs_q[i].addr, obs_q[i].wdata, exp_q[i].wr, exp_q[i].addr, exp_q[i].wdata);
            end
         end
      end
      n_cmp++;
      if (excl_viol !== 0) begin
         n_err++;
         $display("FAIL wr_rd_exclusive: got %0d overlaps want 0", excl_viol);
      end
   endtask

   initial begin
      test_reset();
      test_write_slow();
      test_write();
      test_read();
      test_frame_err();
      test_gap();
      test_bad_cmd();
      test_glitch();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
